// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage: issues one request per load/store,
// stalls the pipeline until ack, flags timeout/misaligned accesses with a sticky error.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        Stall_o,
  output logic [31:0] RdData_o,
  output logic        RdValid_o,
  output logic        Error_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_pending;
  logic w_aligned;
  logic w_busy;
  logic w_last;

  assign w_pending = (r_state == ST_IDLE) && (MemRead_i || MemWrite_i);
  assign w_aligned = (Addr_i[1:0] == 2'b00);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pending) w_next = w_aligned ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        // ack in the final counted cycle still completes normally
        if (mem_ack_i)   w_next = ST_DONE;
        else if (w_last) w_next = ST_ERR;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pending && w_aligned) begin
        r_addr  <= Addr_i[31:2];
        r_wdata <= WrData_i;
        r_we    <= MemWrite_i;
        r_cnt   <= 8'd0;
      end
      if (w_busy) begin
        if (mem_ack_i) begin
          if (!r_we) r_rdata <= mem_rdata_i;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      if (w_next == ST_ERR) r_err <= 1'b1;
    end
  end

  assign mem_req_o   = w_busy;
  assign mem_we_o    = w_busy && r_we;
  assign mem_addr_o  = w_busy ? {r_addr, 2'b00} : 32'd0;
  assign mem_wdata_o = w_busy ? r_wdata : 32'd0;
  // reset term keeps a held request from raising Stall_o while in reset
  assign Stall_o     = rst_i && (w_busy || (w_pending && w_aligned));
  assign RdData_o    = r_rdata;
  assign RdValid_o   = (r_state == ST_DONE) && !r_we;
  assign Error_o     = r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: load, store, misaligned, timeout, read+write,
// stray ack and mid-access reset, each with hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] Addr_i = 32'd0;
  logic [31:0] WrData_i = 32'd0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        Stall_o;
  logic [31:0] RdData_o;
  logic        RdValid_o;
  logic        Error_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_stall = 0;
  int n_req   = 0;
  int n_rdv   = 0;
  int b_stall, b_req, b_rdv;
  bit seen;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .Addr_i     (Addr_i),
    .WrData_i   (WrData_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .Stall_o    (Stall_o),
    .RdData_o   (RdData_o),
    .RdValid_o  (RdValid_o),
    .Error_o    (Error_o)
  );

  always #5 clk_i = ~clk_i;

  // per-cycle activity counts, sampled mid-cycle
  always @(negedge clk_i) begin
    if (Stall_o)   n_stall++;
    if (mem_req_o) n_req++;
    if (RdValid_o) n_rdv++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_stall = n_stall;
    b_req   = n_req;
    b_rdv   = n_rdv;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_stall", 32'(Stall_o), 32'd0);
    chk("rst_rdata", RdData_o, 32'd0);
    chk("rst_rdv", 32'(RdValid_o), 32'd0);
    chk("rst_err", 32'(Error_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;

    // load 0x100, ack in third BUSY cycle
    @(posedge clk_i); #1;
    snap();
    MemRead_i = 1'b1; Addr_i = 32'h100;
    @(negedge clk_i);
    chk("ld_t0_stall", 32'(Stall_o), 32'd1);
    chk("ld_t0_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("ld_req", 32'(mem_req_o), 32'd1);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_we", 32'(mem_we_o), 32'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("ld_done_rdv", 32'(RdValid_o), 32'd1);
    chk("ld_done_rdata", RdData_o, 32'hDEADBEEF);
    chk("ld_done_stall", 32'(Stall_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("ld_idle_rdv", 32'(RdValid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("ld_stall_cycles", 32'(n_stall - b_stall), 32'd4);
    chk("ld_rdv_pulses", 32'(n_rdv - b_rdv), 32'd1);
    chk("ld_err", 32'(Error_o), 32'd0);

    // store 0x204, immediate ack
    snap();
    MemWrite_i = 1'b1; Addr_i = 32'h204; WrData_i = 32'h12345678;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("st_req", 32'(mem_req_o), 32'd1);
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_wdata", mem_wdata_o, 32'h12345678);
    chk("st_addr", mem_addr_o, 32'h204);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("st_stall_cycles", 32'(n_stall - b_stall), 32'd2);
    chk("st_rdv_pulses", 32'(n_rdv - b_rdv), 32'd0);
    chk("st_rdata_kept", RdData_o, 32'hDEADBEEF);

    // stray ack in IDLE
    snap();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    chk("stray_rdata", RdData_o, 32'hDEADBEEF);
    chk("stray_req", 32'(n_req - b_req), 32'd0);
    chk("stray_rdv", 32'(n_rdv - b_rdv), 32'd0);

    // read and write together: treated as a write
    snap();
    MemRead_i = 1'b1; MemWrite_i = 1'b1; Addr_i = 32'h208; WrData_i = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
    @(negedge clk_i);
    chk("rw_we", 32'(mem_we_o), 32'd1);
    chk("rw_wdata", mem_wdata_o, 32'hA5A5A5A5);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("rw_rdv", 32'(n_rdv - b_rdv), 32'd0);
    chk("rw_rdata_kept", RdData_o, 32'hDEADBEEF);

    // load never acked: timeout after 16 request cycles
    snap();
    MemRead_i = 1'b1; Addr_i = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (Error_o) begin
        seen = 1'b1;
        break;
      end
    end
    MemRead_i = 1'b0;
    chk("to_seen", 32'(seen), 32'd1);
    @(negedge clk_i);
    chk("to_stall", 32'(Stall_o), 32'd0);
    chk("to_req_off", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    chk("to_req_cycles", 32'(n_req - b_req), 32'd16);
    chk("to_err", 32'(Error_o), 32'd1);

    // reset pulse clears the sticky error
    rst_i = 1'b0;
    #3;
    chk("rst2_err", 32'(Error_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;

    // misaligned load
    @(posedge clk_i); #1;
    snap();
    MemRead_i = 1'b1; Addr_i = 32'h102;
    @(negedge clk_i);
    chk("mis_stall", 32'(Stall_o), 32'd0);
    chk("mis_err_pre", 32'(Error_o), 32'd0);
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("mis_err", 32'(Error_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("mis_err_sticky", 32'(Error_o), 32'd1);
    chk("mis_req_cycles", 32'(n_req - b_req), 32'd0);
    chk("mis_stall_cycles", 32'(n_stall - b_stall), 32'd0);

    // reset during BUSY, then a normal load after release
    snap();
    MemRead_i = 1'b1; Addr_i = 32'h400;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mr_req_before", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("mr_req_async", 32'(mem_req_o), 32'd0);
    chk("mr_stall_async", 32'(Stall_o), 32'd0);
    chk("mr_addr_async", mem_addr_o, 32'd0);
    chk("mr_err_async", 32'(Error_o), 32'd0);
    @(negedge clk_i);
    chk("mr_rdata_rst", RdData_o, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    chk("mr_req_after", 32'(mem_req_o), 32'd1);
    chk("mr_addr_after", mem_addr_o, 32'h400);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("mr_rdv", 32'(RdValid_o), 32'd1);
    chk("mr_rdata", RdData_o, 32'hCAFEF00D);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("mr_rdv_pulses", 32'(n_rdv - b_rdv), 32'd1);
    chk("mr_err_final", 32'(Error_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
